// File: rtl/wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// wb_stage_pkg
//   Shared constants and helpers for the LA32 write-back stage.
//   Default widths match the register-file and program-counter widths used
//   across the pipeline; the reset level matches the rest of the codebase.
// ---------------------------------------------------------------------------
package wb_stage_pkg;

    localparam int unsigned DEF_PC_W   = 32;    // program counter width
    localparam int unsigned DEF_DATA_W = 32;    // GPR data width
    localparam int unsigned DEF_ADDR_W = 5;     // GPR address width
    localparam int unsigned DEF_CNT_W  = 32;    // retired-instruction counter width

    localparam logic RST_ENABLE = 1'b1;         // reset is active-high

    // The trace port reports a 32-bit GPR write as four byte enables.
    function automatic logic [3:0] trace_byte_en(input logic we);
        return {4{we}};
    endfunction

endpackage : wb_stage_pkg

// File: rtl/wb_stage_pipe_valid_reg.sv
// ---------------------------------------------------------------------------
// wb_stage_pipe_valid_reg
//   Valid bit and valid/allowin handshake for one pipeline stage.
//   Ports:
//     clk       in   stage clock, all state on posedge
//     rst       in   synchronous, active-high reset
//     in_valid  in   upstream offers an instruction
//     stall     in   hold this stage (ready_go = 0)
//     flush     in   discard the stage content at the next edge
//     valid     out  stage holds a valid instruction
//     allowin   out  stage can accept an instruction this cycle
//     ready_go  out  stage content may leave this cycle
// ---------------------------------------------------------------------------
module wb_stage_pipe_valid_reg
    import wb_stage_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic stall,
    input  logic flush,
    output logic valid,
    output logic allowin,
    output logic ready_go
);

    assign ready_go = ~stall;
    // A stage may accept when it is empty or its current occupant leaves.
    assign allowin  = ~valid | ready_go;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;          // flush wins over any incoming instruction
        end else if (allowin) begin
            valid <= in_valid;
        end
    end

endmodule : wb_stage_pipe_valid_reg

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
//   Write-back stage of the LA32 5-stage pipeline. Takes the MEM result over
//   a valid/allowin handshake, writes the register file exactly once per
//   retired instruction, drives the debug trace port and counts retirements.
//   Ports:
//     wb_in_clk          in   clock
//     wb_in_rstL         in   synchronous reset, active-high
//     wb_in_mem_valid    in   MEM offers an instruction
//     wb_out_allowin     out  WB can accept this cycle
//     wb_in_mem_pc/we/waddr/wdata  in  payload of the offered instruction
//     wb_in_stall        in   hold WB this cycle
//     wb_in_flush        in   discard WB content at the next edge
//     wb_out_valid       out  WB holds a valid instruction
//     wb_out_rf_we/waddr/wdata     out regfile write port
//     debug_wb_pc/rf_we/rf_wnum/rf_wdata  out trace port
//     wb_out_retire_cnt  out  number of retired instructions (wraps)
// ---------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned PC_W   = DEF_PC_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              wb_in_clk,
    input  logic              wb_in_rstL,
    input  logic              wb_in_mem_valid,
    output logic              wb_out_allowin,
    input  logic [PC_W-1:0]   wb_in_mem_pc,
    input  logic              wb_in_mem_we,
    input  logic [ADDR_W-1:0] wb_in_mem_waddr,
    input  logic [DATA_W-1:0] wb_in_mem_wdata,
    input  logic              wb_in_stall,
    input  logic              wb_in_flush,
    output logic              wb_out_valid,
    output logic              wb_out_rf_we,
    output logic [ADDR_W-1:0] wb_out_rf_waddr,
    output logic [DATA_W-1:0] wb_out_rf_wdata,
    output logic [PC_W-1:0]   debug_wb_pc,
    output logic [3:0]        debug_wb_rf_we,
    output logic [ADDR_W-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata,
    output logic [CNT_W-1:0]  wb_out_retire_cnt
);

    logic              valid;
    logic              ready_go;
    logic              allowin;
    logic              retire;
    logic              rf_we;

    logic [PC_W-1:0]   pay_pc;
    logic              pay_we;
    logic [ADDR_W-1:0] pay_waddr;
    logic [DATA_W-1:0] pay_wdata;
    logic [CNT_W-1:0]  retire_cnt;

    wb_stage_pipe_valid_reg u_valid (
        .clk      (wb_in_clk),
        .rst      (wb_in_rstL),
        .in_valid (wb_in_mem_valid),
        .stall    (wb_in_stall),
        .flush    (wb_in_flush),
        .valid    (valid),
        .allowin  (allowin),
        .ready_go (ready_go)
    );

    // NOTE: the payload registers are reset too, because the trace port and
    // regfile address/data outputs expose them directly and must read 0
    // out of reset.
    always_ff @(posedge wb_in_clk) begin
        if (wb_in_rstL == RST_ENABLE) begin
            pay_pc    <= '0;
            pay_we    <= 1'b0;
            pay_waddr <= '0;
            pay_wdata <= '0;
        end else if (allowin && wb_in_mem_valid && !wb_in_flush) begin
            pay_pc    <= wb_in_mem_pc;
            pay_we    <= wb_in_mem_we;
            pay_waddr <= wb_in_mem_waddr;
            pay_wdata <= wb_in_mem_wdata;
        end
    end

    // An instruction leaves WB in the cycle it is valid and not stalled.
    // Gating the write with ready_go keeps a stalled instruction from writing
    // the regfile more than once.
    assign retire = valid & ready_go;
    assign rf_we  = retire & pay_we & (pay_waddr != '0);   // r0 is never written

    always_ff @(posedge wb_in_clk) begin
        if (wb_in_rstL == RST_ENABLE) begin
            retire_cnt <= '0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + CNT_W'(1);           // wraps naturally
        end
    end

    assign wb_out_allowin    = allowin;
    assign wb_out_valid      = valid;
    assign wb_out_rf_we      = rf_we;
    assign wb_out_rf_waddr   = pay_waddr;
    assign wb_out_rf_wdata   = pay_wdata;
    assign debug_wb_pc       = valid ? pay_pc : '0;
    assign debug_wb_rf_we    = trace_byte_en(rf_we);
    assign debug_wb_rf_wnum  = pay_waddr;
    assign debug_wb_rf_wdata = pay_wdata;
    assign wb_out_retire_cnt = retire_cnt;

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
//   Directed bench for wb_stage. Stimulus pushes the expected retirement of
//   every offered instruction into a queue; a monitor pops one entry per
//   observed retirement (valid & allowin) and compares the regfile and trace
//   ports. A second instance with a 4-bit counter exercises counter wrap.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_stage;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        rf_we;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_pc = '0;
    logic        mem_we = 1'b0;
    logic [4:0]  mem_waddr = '0;
    logic [31:0] mem_wdata = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic        allowin, valid, rf_we;
    logic [4:0]  rf_waddr, dbg_wnum;
    logic [31:0] rf_wdata, dbg_pc, dbg_wdata, retire_cnt;
    logic [3:0]  dbg_we;

    // small-counter instance for the wrap check
    logic        w_mem_valid = 1'b0;
    logic        w_allowin, w_valid, w_rf_we;
    logic [4:0]  w_rf_waddr, w_dbg_wnum;
    logic [31:0] w_rf_wdata, w_dbg_pc, w_dbg_wdata;
    logic [3:0]  w_dbg_we;
    logic [3:0]  w_cnt;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt = '0;
    logic [31:0] cnt_snap;

    always #5 clk = ~clk;

    wb_stage dut (
        .wb_in_clk        (clk),
        .wb_in_rstL       (rst),
        .wb_in_mem_valid  (mem_valid),
        .wb_out_allowin   (allowin),
        .wb_in_mem_pc     (mem_pc),
        .wb_in_mem_we     (mem_we),
        .wb_in_mem_waddr  (mem_waddr),
        .wb_in_mem_wdata  (mem_wdata),
        .wb_in_stall      (stall),
        .wb_in_flush      (flush),
        .wb_out_valid     (valid),
        .wb_out_rf_we     (rf_we),
        .wb_out_rf_waddr  (rf_waddr),
        .wb_out_rf_wdata  (rf_wdata),
        .debug_wb_pc      (dbg_pc),
        .debug_wb_rf_we   (dbg_we),
        .debug_wb_rf_wnum (dbg_wnum),
        .debug_wb_rf_wdata(dbg_wdata),
        .wb_out_retire_cnt(retire_cnt)
    );

    wb_stage #(.CNT_W(4)) dut_wrap (
        .wb_in_clk        (clk),
        .wb_in_rstL       (rst),
        .wb_in_mem_valid  (w_mem_valid),
        .wb_out_allowin   (w_allowin),
        .wb_in_mem_pc     (32'h1c00_0000),
        .wb_in_mem_we     (1'b1),
        .wb_in_mem_waddr  (5'd3),
        .wb_in_mem_wdata  (32'h0000_0033),
        .wb_in_stall      (1'b0),
        .wb_in_flush      (1'b0),
        .wb_out_valid     (w_valid),
        .wb_out_rf_we     (w_rf_we),
        .wb_out_rf_waddr  (w_rf_waddr),
        .wb_out_rf_wdata  (w_rf_wdata),
        .debug_wb_pc      (w_dbg_pc),
        .debug_wb_rf_we   (w_dbg_we),
        .debug_wb_rf_wnum (w_dbg_wnum),
        .debug_wb_rf_wdata(w_dbg_wdata),
        .wb_out_retire_cnt(w_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic we, input logic [4:0] waddr,
                         input logic [31:0] wdata, input logic exp_rf_we);
        exp_t e;
        mem_valid = 1'b1;
        mem_pc    = pc;
        mem_we    = we;
        mem_waddr = waddr;
        mem_wdata = wdata;
        e.pc = pc; e.waddr = waddr; e.wdata = wdata; e.rf_we = exp_rf_we;
        sb.push_back(e);
    endtask

    task automatic idle();
        mem_valid = 1'b0;
        mem_pc    = '0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
    endtask

    task automatic check_empty_stage(input string tag);
        check({tag, "_valid"},   valid,      0);
        check({tag, "_allowin"}, allowin,    1);
        check({tag, "_rf_we"},   rf_we,      0);
        check({tag, "_waddr"},   rf_waddr,   0);
        check({tag, "_wdata"},   rf_wdata,   0);
        check({tag, "_dbg_pc"},  dbg_pc,     0);
        check({tag, "_dbg_we"},  dbg_we,     0);
        check({tag, "_cnt"},     retire_cnt, 0);
    endtask

    // Monitor: one scoreboard entry per retirement.
    always @(negedge clk) begin
        if (rst) begin
            exp_cnt = '0;
        end else if (valid === 1'b1 && allowin === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_retire_pc", dbg_pc, 0);
                n_err++;
                $display("FAIL retire_without_expectation: got pc 0x%0h, expected none", dbg_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ret_dbg_pc",    dbg_pc,     e.pc);
                check("ret_rf_we",     rf_we,      e.rf_we);
                check("ret_rf_waddr",  rf_waddr,   e.waddr);
                check("ret_rf_wdata",  rf_wdata,   e.wdata);
                check("ret_dbg_we",    dbg_we,     e.rf_we ? 4'hf : 4'h0);
                check("ret_dbg_wnum",  dbg_wnum,   e.waddr);
                check("ret_dbg_wdata", dbg_wdata,  e.wdata);
                check("ret_cnt_before", retire_cnt, exp_cnt);
            end
            exp_cnt = exp_cnt + 32'd1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset for 3 cycles with a valid offer present
        rst = 1'b1;
        mem_valid = 1'b1; mem_pc = 32'hffff_fff0; mem_we = 1'b1;
        mem_waddr = 5'd9; mem_wdata = 32'hcafe_f00d;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_empty_stage("reset");
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        @(negedge clk);
        check_empty_stage("post_reset");

        // 2: back-to-back stream, one retirement per cycle
        step();
        for (int i = 0; i < 4; i++) begin
            offer(32'h1c00_0000 + 32'(4 * i), 1'b1, 5'(i + 1), 32'h0000_0100 + 32'(i), 1'b1);
            step();
        end
        idle();
        step();
        @(negedge clk);
        check("stream_cnt", retire_cnt, 4);
        check("stream_idle_valid", valid, 0);

        // 3: stall holds payload and suppresses the write; a pending offer
        // is accepted only once the stall drops
        step();
        offer(32'h1c00_0010, 1'b1, 5'd5, 32'hdead_beef, 1'b1);
        step();
        stall = 1'b1;
        offer(32'h1c00_0014, 1'b1, 5'd6, 32'h0000_0066, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_rf_we",   rf_we,      0);
            check("stall_allowin", allowin,    0);
            check("stall_waddr",   rf_waddr,   5);
            check("stall_wdata",   rf_wdata,   32'hdead_beef);
            check("stall_dbg_pc",  dbg_pc,     32'h1c00_0010);
            check("stall_cnt",     retire_cnt, 4);
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        check("unstall_rf_we", rf_we, 1);
        step();
        idle();
        step();
        @(negedge clk);
        check("stall_cnt_after", retire_cnt, 6);

        // 4: r0 destination retires and counts but never writes
        offer(32'h1c00_0018, 1'b1, 5'd0, 32'h1234_5678, 1'b0);
        step();
        idle();
        step();
        @(negedge clk);
        check("r0_cnt", retire_cnt, 7);

        // 5: flush under stall with a new offer present
        offer(32'h1c00_001c, 1'b1, 5'd7, 32'h0000_0077, 1'b1);
        step();
        stall = 1'b1;
        flush = 1'b1;
        void'(sb.pop_back());   // this instruction is discarded
        mem_pc = 32'h1c00_0020; mem_waddr = 5'd8; mem_wdata = 32'h0000_0088;
        @(negedge clk);
        check("flush_cycle_rf_we", rf_we, 0);
        cnt_snap = retire_cnt;
        step();
        flush = 1'b0;
        stall = 1'b0;
        idle();
        @(negedge clk);
        check("flush_valid",  valid,      0);
        check("flush_rf_we",  rf_we,      0);
        check("flush_cnt",    retire_cnt, cnt_snap);
        check("flush_cnt_abs", retire_cnt, 7);
        step();
        @(negedge clk);
        check("flush_no_take", valid, 0);

        // reset while a stalled instruction is held: no write, no count
        offer(32'h1c00_0024, 1'b1, 5'd9, 32'h0000_0099, 1'b1);
        step();
        stall = 1'b1;
        idle();
        step();
        rst = 1'b1;
        void'(sb.pop_back());
        step();
        @(negedge clk);
        check("rst_stall_rf_we", rf_we, 0);
        rst = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check_empty_stage("rst_stall");

        // 6: counter wrap on the 4-bit-counter instance
        step();
        w_mem_valid = 1'b1;
        repeat (16) step();
        @(negedge clk);
        check("wrap_cnt_max", w_cnt, 4'hf);
        step();
        w_mem_valid = 1'b0;
        @(negedge clk);
        check("wrap_cnt_zero", w_cnt, 4'h0);

        repeat (3) step();
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wb_stage
